// File: rtl/hpm_counter_bank.sv
// hpm_counter_bank
// ----------------
// Bank of NUM_CNT machine performance counters for the CSR unit.
// Each channel adds a small per-cycle event count and can be inhibited.
// A carry out of the top bit sets a sticky overflow flag. Overflow flags
// gated by ovf_ie raise ovf_irq. High-half reads are made tear-free by a
// snapshot that is taken on a low-half read.
//
// Ports:
//   clk, rst              core clock, asynchronous active-high reset
//   event_cnt             per-channel increment, channel i at [i*INC_W +: INC_W]
//   csr_we/sel/idx/wdata  write port; sel 0 = low 32, 1 = high, 2 = inhibit,
//                         3 = overflow write-1-to-clear
//   rd_en/rd_sel/rd_idx   read request, same target encoding as csr_sel
//   rd_data, rd_valid     registered read result, one cycle after rd_en
//   ovf_ie, ovf_irq       per-channel interrupt enable, registered interrupt
module hpm_counter_bank #(
    parameter int NUM_CNT   = 4,
    parameter int CNT_WIDTH = 64,
    parameter int INC_W     = 2,
    parameter int IDX_W     = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CNT*INC_W-1:0]   event_cnt,
    input  logic                       csr_we,
    input  logic [1:0]                 csr_sel,
    input  logic [IDX_W-1:0]           csr_idx,
    input  logic [31:0]                csr_wdata,
    input  logic                       rd_en,
    input  logic [1:0]                 rd_sel,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic [31:0]                rd_data,
    output logic                       rd_valid,
    input  logic [NUM_CNT-1:0]         ovf_ie,
    output logic                       ovf_irq
);

    localparam int          HI_W      = CNT_WIDTH - 32;
    localparam logic [31:0] NUM_CNT_U = 32'(NUM_CNT);

    // State
    logic [CNT_WIDTH-1:0] cnt_q [NUM_CNT];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_CNT];
    logic [NUM_CNT-1:0]   inh_q, inh_d;
    logic [NUM_CNT-1:0]   ovf_q, ovf_d;
    logic [HI_W-1:0]      shadow_q, shadow_d;
    logic                 shadow_vld_q, shadow_vld_d;
    logic [IDX_W-1:0]     shadow_idx_q, shadow_idx_d;
    logic [31:0]          rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 ovf_irq_q, ovf_irq_d;

    // Combinational helpers
    logic                 csr_idx_ok;
    logic                 rd_idx_ok;
    logic                 wr_cnt;
    logic [CNT_WIDTH:0]   inc_sum [NUM_CNT];
    logic [NUM_CNT-1:0]   ovf_set;
    logic [NUM_CNT-1:0]   ovf_clr;
    logic [CNT_WIDTH-1:0] rd_cnt;

    assign csr_idx_ok = (32'(csr_idx) < NUM_CNT_U);
    assign rd_idx_ok  = (32'(rd_idx) < NUM_CNT_U);
    assign wr_cnt     = csr_we && ((csr_sel == 2'd0) || (csr_sel == 2'd1)) && csr_idx_ok;

    // Counter increment / half-write and overflow detection per channel
    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            // One extra bit catches the carry out of the top counter bit.
            inc_sum[i] = {1'b0, cnt_q[i]} + (CNT_WIDTH+1)'(event_cnt[i*INC_W +: INC_W]);
            if (wr_cnt && (csr_idx == IDX_W'(i))) begin
                // A CSR write replaces this cycle's increment and never flags overflow.
                ovf_set[i] = 1'b0;
                if (csr_sel == 2'd0) begin
                    cnt_d[i] = {cnt_q[i][CNT_WIDTH-1:32], csr_wdata};
                end else begin
                    cnt_d[i] = {csr_wdata[HI_W-1:0], cnt_q[i][31:0]};
                end
            end else if (!inh_q[i]) begin
                cnt_d[i]   = inc_sum[i][CNT_WIDTH-1:0];
                ovf_set[i] = inc_sum[i][CNT_WIDTH];
            end else begin
                cnt_d[i]   = cnt_q[i];
                ovf_set[i] = 1'b0;
            end
        end
    end

    // Inhibit mask, overflow flags and interrupt request next state
    always_comb begin
        if (csr_we && (csr_sel == 2'd2)) begin
            inh_d = csr_wdata[NUM_CNT-1:0];
        end else begin
            inh_d = inh_q;
        end
        if (csr_we && (csr_sel == 2'd3)) begin
            ovf_clr = csr_wdata[NUM_CNT-1:0];
        end else begin
            ovf_clr = {NUM_CNT{1'b0}};
        end
        // Set is OR-ed in after the clear so a simultaneous set wins.
        ovf_d     = (ovf_q & ~ovf_clr) | ovf_set;
        ovf_irq_d = |(ovf_q & ovf_ie);
    end

    // Read mux and split-read snapshot bookkeeping
    always_comb begin
        if (rd_idx_ok) begin
            rd_cnt = cnt_q[rd_idx];
        end else begin
            rd_cnt = {CNT_WIDTH{1'b0}};
        end
        rd_data_d    = rd_data_q;
        rd_valid_d   = rd_en;
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
        shadow_idx_d = shadow_idx_q;
        if (rd_en) begin
            case (rd_sel)
                2'd0: begin
                    rd_data_d = rd_cnt[31:0];
                    if (rd_idx_ok) begin
                        shadow_d     = rd_cnt[CNT_WIDTH-1:32];
                        shadow_vld_d = 1'b1;
                        shadow_idx_d = rd_idx;
                    end else begin
                        shadow_vld_d = shadow_vld_q;
                    end
                end
                2'd1: begin
                    if (shadow_vld_q && (shadow_idx_q == rd_idx)) begin
                        rd_data_d = 32'(shadow_q);
                    end else begin
                        rd_data_d = 32'(rd_cnt[CNT_WIDTH-1:32]);
                    end
                    shadow_vld_d = 1'b0;
                end
                2'd2:    rd_data_d = 32'(inh_q);
                2'd3:    rd_data_d = 32'(ovf_q);
                default: rd_data_d = 32'd0;
            endcase
        end else begin
            rd_data_d = rd_data_q;
        end
        // Compared against the post-read index so a snapshot taken in the
        // same cycle as a write to that channel is discarded as stale.
        if (wr_cnt && (csr_idx == shadow_idx_d)) begin
            shadow_vld_d = 1'b0;
        end else begin
            shadow_vld_d = shadow_vld_d;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= {CNT_WIDTH{1'b0}};
            end
            inh_q        <= {NUM_CNT{1'b0}};
            ovf_q        <= {NUM_CNT{1'b0}};
            shadow_q     <= {HI_W{1'b0}};
            shadow_vld_q <= 1'b0;
            shadow_idx_q <= {IDX_W{1'b0}};
            rd_data_q    <= 32'd0;
            rd_valid_q   <= 1'b0;
            ovf_irq_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            inh_q        <= inh_d;
            ovf_q        <= ovf_d;
            shadow_q     <= shadow_d;
            shadow_vld_q <= shadow_vld_d;
            shadow_idx_q <= shadow_idx_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            ovf_irq_q    <= ovf_irq_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign ovf_irq  = ovf_irq_q;

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Directed, table-driven bench for hpm_counter_bank (default parameters:
// 4 channels, 64-bit counters, 2-bit increments).
module tb_hpm_counter_bank;

    logic        clk;
    logic        rst;
    logic [7:0]  event_cnt;
    logic        csr_we;
    logic [1:0]  csr_sel;
    logic [1:0]  csr_idx;
    logic [31:0] csr_wdata;
    logic        rd_en;
    logic [1:0]  rd_sel;
    logic [1:0]  rd_idx;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [3:0]  ovf_ie;
    logic        ovf_irq;

    int n_cmp = 0;
    int n_bad = 0;

    hpm_counter_bank dut (
        .clk       (clk),
        .rst       (rst),
        .event_cnt (event_cnt),
        .csr_we    (csr_we),
        .csr_sel   (csr_sel),
        .csr_idx   (csr_idx),
        .csr_wdata (csr_wdata),
        .rd_en     (rd_en),
        .rd_sel    (rd_sel),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .ovf_ie    (ovf_ie),
        .ovf_irq   (ovf_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  sel;
        logic [1:0]  idx;
        logic [31:0] wd;
        logic        re;
        logic [1:0]  rsel;
        logic [1:0]  ridx;
        logic [7:0]  ev;
        logic [3:0]  ie;
        int          rep;
        logic        chk_d;
        logic [31:0] exp_d;
        logic        exp_v;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic we, logic [1:0] sel, logic [1:0] idx, logic [31:0] wd,
                                logic re, logic [1:0] rsel, logic [1:0] ridx,
                                logic [7:0] ev, logic [3:0] ie, int rep,
                                logic chk_d, logic [31:0] exp_d, logic exp_v, logic exp_irq);
        vec_t v;
        v.we = we; v.sel = sel; v.idx = idx; v.wd = wd;
        v.re = re; v.rsel = rsel; v.ridx = ridx;
        v.ev = ev; v.ie = ie; v.rep = rep;
        v.chk_d = chk_d; v.exp_d = exp_d; v.exp_v = exp_v; v.exp_irq = exp_irq;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] sel, input logic [1:0] idx,
                         input logic [31:0] wd, input logic re, input logic [1:0] rsel,
                         input logic [1:0] ridx, input logic [7:0] ev, input logic [3:0] ie);
        csr_we = we; csr_sel = sel; csr_idx = idx; csr_wdata = wd;
        rd_en = re; rd_sel = rsel; rd_idx = ridx;
        event_cnt = ev; ovf_ie = ie;
    endtask

    task automatic run_vec(input int k, input vec_t v);
        drive(v.we, v.sel, v.idx, v.wd, v.re, v.rsel, v.ridx, v.ev, v.ie);
        repeat (v.rep) @(posedge clk);
        #1;
        check($sformatf("v%0d rd_valid", k), 32'(rd_valid), 32'(v.exp_v));
        check($sformatf("v%0d ovf_irq", k), 32'(ovf_irq), 32'(v.exp_irq));
        if (v.chk_d) begin
            check($sformatf("v%0d rd_data", k), rd_data, v.exp_d);
        end
    endtask

    // One idle cycle with a read, checking the returned data
    task automatic read_chk(input string name, input logic [1:0] rsel, input logic [1:0] ridx,
                            input logic [31:0] exp);
        drive(1'b0, 2'd0, 2'd0, 32'd0, 1'b1, rsel, ridx, 8'h00, 4'h0);
        @(posedge clk);
        #1;
        check({name, " valid"}, 32'(rd_valid), 32'd1);
        check({name, " data"}, rd_data, exp);
    endtask

    initial begin
        //               we  sel   idx   wdata          re  rsel  ridx  ev     ie     rep chk exp_d          v     irq
        // ch0 counts +2 for 10 cycles, then low/high reads
        tbl.push_back(mk(0, 2'd0, 2'd0, 32'h0,          0, 2'd0, 2'd0, 8'h02, 4'h0, 10, 0, 32'h0,          0, 0));
        tbl.push_back(mk(0, 2'd0, 2'd0, 32'h0,          1, 2'd0, 2'd0, 8'h00, 4'h0, 1,  1, 32'd20,         1, 0));
        tbl.push_back(mk(0, 2'd0, 2'd0, 32'h0,          0, 2'd0, 2'd0, 8'h00, 4'h0, 1,  0, 32'h0,          0, 0));
        tbl.push_back(mk(0, 2'd0, 2'd0, 32'h0,          1, 2'd1, 2'd0, 8'h00, 4'h0, 1,  1, 32'h0,          1, 0));
        // ch1 to all-ones; write to the just-snapshotted channel drops the snapshot
        tbl.push_back(mk(1, 2'd0, 2'd1, 32'hFFFF_FFFF,  0, 2'd0, 2'd0, 8'h00, 4'h0, 1,  0, 32'h0,          0, 0));
        tbl.push_back(mk(1, 2'd1, 2'd1, 32'hFFFF_FFFF,  1, 2'd0, 2'd1, 8'h00, 4'h0, 1,  1, 32'hFFFF_FFFF,  1, 0));
        tbl.push_back(mk(0, 2'd0, 2'd0, 32'h0,          1, 2'd1, 2'd1, 8'h0C, 4'h2, 1,  1, 32'hFFFF_FFFF,  1, 0));
        tbl.push_back(mk(0, 2'd0, 2'd0, 32'h0,          1, 2'd3, 2'd0, 8'h00, 4'h2, 1,  1, 32'h2,          1, 1));
        tbl.push_back(mk(1, 2'd3, 2'd0, 32'h2,          1, 2'd0, 2'd1, 8'h00, 4'h2, 1,  1, 32'h2,          1, 1));
        tbl.push_back(mk(0, 2'd0, 2'd0, 32'h0,          1, 2'd3, 2'd0, 8'h00, 4'h2, 1,  1, 32'h0,          1, 0));
        tbl.push_back(mk(0, 2'd0, 2'd0, 32'h0,          1, 2'd1, 2'd1, 8'h00, 4'h2, 1,  1, 32'h0,          1, 0));
        // inhibit ch2 while ch0 and ch2 both count +1
        tbl.push_back(mk(1, 2'd2, 2'd0, 32'h4,          0, 2'd0, 2'd0, 8'h11, 4'h0, 1,  0, 32'h0,          0, 0));
        tbl.push_back(mk(0, 2'd0, 2'd0, 32'h0,          1, 2'd2, 2'd0, 8'h11, 4'h0, 1,  1, 32'h4,          1, 0));
        tbl.push_back(mk(0, 2'd0, 2'd0, 32'h0,          1, 2'd0, 2'd2, 8'h11, 4'h0, 1,  1, 32'd1,          1, 0));
        tbl.push_back(mk(1, 2'd2, 2'd0, 32'h0,          1, 2'd0, 2'd0, 8'h11, 4'h0, 1,  1, 32'd23,         1, 0));
        tbl.push_back(mk(0, 2'd0, 2'd0, 32'h0,          1, 2'd0, 2'd2, 8'h11, 4'h0, 1,  1, 32'd1,          1, 0));
        tbl.push_back(mk(0, 2'd0, 2'd0, 32'h0,          1, 2'd0, 2'd2, 8'h00, 4'h0, 1,  1, 32'd2,          1, 0));
        tbl.push_back(mk(0, 2'd0, 2'd0, 32'h0,          1, 2'd0, 2'd0, 8'h00, 4'h0, 1,  1, 32'd25,         1, 0));
        // snapshot across the low-to-high carry
        tbl.push_back(mk(1, 2'd0, 2'd0, 32'hFFFF_FFFF,  0, 2'd0, 2'd0, 8'h00, 4'h0, 1,  0, 32'h0,          0, 0));
        tbl.push_back(mk(1, 2'd1, 2'd0, 32'h0,          0, 2'd0, 2'd0, 8'h00, 4'h0, 1,  0, 32'h0,          0, 0));
        tbl.push_back(mk(0, 2'd0, 2'd0, 32'h0,          1, 2'd0, 2'd0, 8'h01, 4'h0, 1,  1, 32'hFFFF_FFFF,  1, 0));
        tbl.push_back(mk(0, 2'd0, 2'd0, 32'h0,          1, 2'd1, 2'd0, 8'h01, 4'h0, 1,  1, 32'h0,          1, 0));
        tbl.push_back(mk(0, 2'd0, 2'd0, 32'h0,          1, 2'd1, 2'd0, 8'h00, 4'h0, 1,  1, 32'h1,          1, 0));
        tbl.push_back(mk(0, 2'd0, 2'd0, 32'h0,          1, 2'd0, 2'd0, 8'h00, 4'h0, 1,  1, 32'h1,          1, 0));
        // write beats a same-cycle increment; same-cycle read sees the old value
        tbl.push_back(mk(1, 2'd0, 2'd0, 32'd5,          1, 2'd0, 2'd0, 8'h01, 4'h0, 1,  1, 32'h1,          1, 0));
        tbl.push_back(mk(0, 2'd0, 2'd0, 32'h0,          1, 2'd0, 2'd0, 8'h00, 4'h0, 1,  1, 32'd5,          1, 0));
        // ch3 wraps by +2 with its interrupt masked, then ovf_ie rises
        tbl.push_back(mk(1, 2'd0, 2'd3, 32'hFFFF_FFFE,  0, 2'd0, 2'd0, 8'h00, 4'h0, 1,  0, 32'h0,          0, 0));
        tbl.push_back(mk(1, 2'd1, 2'd3, 32'hFFFF_FFFF,  0, 2'd0, 2'd0, 8'h00, 4'h0, 1,  0, 32'h0,          0, 0));
        tbl.push_back(mk(0, 2'd0, 2'd0, 32'h0,          1, 2'd3, 2'd0, 8'h80, 4'h0, 1,  1, 32'h0,          1, 0));
        tbl.push_back(mk(0, 2'd0, 2'd0, 32'h0,          1, 2'd3, 2'd0, 8'h00, 4'h0, 1,  1, 32'h8,          1, 0));
        tbl.push_back(mk(0, 2'd0, 2'd0, 32'h0,          0, 2'd0, 2'd0, 8'h00, 4'h8, 1,  0, 32'h0,          0, 1));
        tbl.push_back(mk(0, 2'd0, 2'd0, 32'h0,          0, 2'd0, 2'd0, 8'h00, 4'h0, 1,  0, 32'h0,          0, 0));
        tbl.push_back(mk(0, 2'd0, 2'd0, 32'h0,          1, 2'd0, 2'd3, 8'h00, 4'h0, 1,  1, 32'h0,          1, 0));
        // set and clear of ovf[1] in the same cycle: set wins
        tbl.push_back(mk(1, 2'd0, 2'd1, 32'hFFFF_FFFF,  0, 2'd0, 2'd0, 8'h00, 4'h0, 1,  0, 32'h0,          0, 0));
        tbl.push_back(mk(1, 2'd1, 2'd1, 32'hFFFF_FFFF,  0, 2'd0, 2'd0, 8'h00, 4'h0, 1,  0, 32'h0,          0, 0));
        tbl.push_back(mk(1, 2'd3, 2'd0, 32'h2,          0, 2'd0, 2'd0, 8'h04, 4'h0, 1,  0, 32'h0,          0, 0));
        tbl.push_back(mk(1, 2'd3, 2'd0, 32'h8,          1, 2'd3, 2'd0, 8'h00, 4'h0, 1,  1, 32'hA,          1, 0));
        tbl.push_back(mk(0, 2'd0, 2'd0, 32'h0,          1, 2'd3, 2'd0, 8'h00, 4'h0, 1,  1, 32'h2,          1, 0));

        // Power-on reset
        drive(1'b0, 2'd0, 2'd0, 32'd0, 1'b0, 2'd0, 2'd0, 8'h00, 4'h0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset rd_data", rd_data, 32'h0);
        check("reset rd_valid", 32'(rd_valid), 32'd0);
        check("reset ovf_irq", 32'(ovf_irq), 32'd0);
        rst = 1'b0;

        for (int k = 0; k < tbl.size(); k++) begin
            run_vec(k, tbl[k]);
        end

        // Reset in the middle of a read stream with ch0 = {1, 5}
        drive(1'b0, 2'd0, 2'd0, 32'd0, 1'b1, 2'd0, 2'd0, 8'h01, 4'h0);
        @(posedge clk);
        #1;
        check("pre-rst valid", 32'(rd_valid), 32'd1);
        check("pre-rst data", rd_data, 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check("mid-rst valid", 32'(rd_valid), 32'd0);
        check("mid-rst data", rd_data, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post-rst valid", 32'(rd_valid), 32'd0);
        read_chk("post-rst ch0 lo", 2'd0, 2'd0, 32'h0);
        read_chk("post-rst ch0 hi", 2'd1, 2'd0, 32'h0);
        read_chk("post-rst ch1 lo", 2'd0, 2'd1, 32'h0);
        read_chk("post-rst ch3 hi", 2'd1, 2'd3, 32'h0);
        read_chk("post-rst inh", 2'd2, 2'd0, 32'h0);
        read_chk("post-rst ovf", 2'd3, 2'd0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
